vga_sync_controller: RTL and testbench
======================================

Name: vga_sync_controller

Overview:
- Raster timing generator and pixel output stage for the VGA display path.
- Generates horizontal and vertical counters, hsync and vsync, and blanking.
- Publishes the current pixel coordinate so the colour-function multiplexer can produce a DATA_WIDTH RGB word.
- Registers that word onto the DAC pins, aligned with sync and blank. It sits between the pattern/colour multiplexer and the board video DAC.

Parameters:
- DATA_WIDTH, 24, packed RGB width; R=[23:16], G=[15:8], B=[7:0]; must be divisible by 3.
- COORD_W, 10, width of pixel_x/pixel_y; must hold H_TOTAL-1 and V_TOTAL-1.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, hsync pulse width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vsync pulse width (lines).
- V_BP, 33, vertical back porch (lines).
- SYNC_ACTIVE, 0, logic level of an asserted hsync/vsync (0 = active-low).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- pix_en  input  1  pixel tick; counters and the output stage advance only when 1 (e.g. 25 MHz tick from a 50 MHz clk)
- pixel_in  input  DATA_WIDTH  colour for (pixel_x, pixel_y), from the multiplexer, valid in the same cycle
- pixel_x  output  COORD_W  current horizontal count
- pixel_y  output  COORD_W  current vertical count
- video_on  output  1  1 when the current count is inside the active area
- frame_start  output  1  one-clk pulse at count (0,0)
- vga_r / vga_g / vga_b  output  DATA_WIDTH/3 each  registered colour to DAC
- vga_hsync  output  1  registered hsync
- vga_vsync  output  1  registered vsync
- vga_blank_n  output  1  registered, 0 during blanking
- vga_sync_n  output  1  tied 0 (no sync-on-green)
- vga_clk  output  1  registered copy of pix_en, used as DAC strobe

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset (synchronous, priority over pix_en):
  - h_count and v_count = 0.
  - vga_hsync and vga_vsync = !SYNC_ACTIVE.
  - vga_blank_n = 0; RGB = 0; frame_start = 0; vga_clk = 0.
  - Reset mid-frame restarts at (0,0) on the next clk.
- Counting on pix_en=1:
  - h_count increments; at H_TOTAL-1 it wraps to 0 and v_count increments.
  - v_count wraps to 0 when it is at V_TOTAL-1 and h_count wraps (both wrap in the same cycle).
  - With pix_en=0 everything holds, including outputs.
- pixel_x/pixel_y = h_count/v_count, driven straight from the counter registers.
- video_on = (h_count < H_ACTIVE) && (v_count < V_ACTIVE), combinational from the counters.
- Sync decode:
  - hsync is asserted when H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync is asserted when V_ACTIVE+V_FP <= v_count < V_ACTIVE+V_FP+V_SYNC (490..491).
- Output stage, one pixel of latency, updated on pix_en=1:
  - RGB <= video_on ? pixel_in : 0.
  - vga_blank_n <= video_on.
  - vga_hsync and vga_vsync <= decoded sync levels.
  - All DAC outputs therefore describe the count that was current one pixel earlier, and stay mutually aligned.
- frame_start = 1 for exactly one clk, in the cycle where pix_en=1 and the counters are at (0,0). It is not asserted during reset.
- pixel_in is ignored (output forced 0) outside the active area.

Decomposition:
- Package vga_pkg holds:
  - the default 640x480@60 timing constants (H_ACTIVE ... V_BP);
  - a typedef rgb_t (packed struct r,g,b of 8 bits each);
  - a function that returns the total from four timing fields.
- Sub-module vga_counter, instantiated twice (horizontal, vertical):
  - parameters MAX and W; ports clk, reset, en, count, wrap.
  - The horizontal wrap drives the vertical en (ANDed with pix_en).

Test Plan:
- Assert reset for 3 clks with pix_en=1 → pixel_x=0, pixel_y=0, vga_hsync=vga_vsync=1, vga_blank_n=0, RGB=0.
- pix_en=1 constantly for 800 ticks → vga_hsync low for exactly 96 ticks starting one tick after h_count=656; pixel_y goes 0→1 when pixel_x wraps 799→0.
- Run a full frame of 420000 ticks → vga_vsync low for exactly 1600 ticks (lines 490–491, delayed one tick); frame_start pulses once per 420000 ticks.
- pixel_in = {8'hFF,8'h00,8'h80} held → vga_r=FF, vga_g=00, vga_b=80 during active pixels, one tick after the coordinate; 0 while h_count ≥ 640 or v_count ≥ 480.
- pix_en toggling 1,0,1,0 with a 50 MHz clk → counters advance every second clk; an 800-pixel line takes 1600 clks; outputs are stable across pix_en=0 cycles.
- Assert reset at (h=300, v=200) → next clk pixel_x=0, pixel_y=0, vga_blank_n=0; the first frame_start follows the first pix_en after reset is released.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - default 640x480@60 raster timing, colour type and timing helper
package vga_pkg;

    // Horizontal timing, in pixels.
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;

    // Vertical timing, in lines.
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    // Packed 24-bit colour as seen on the DAC pins: r in [23:16], b in [7:0].
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Period of one raster axis from its four timing fields.
    function automatic int timing_total(input int active, input int fp,
                                        input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_counter.sv
// rtl/vga_counter.sv - modulo-MAX raster axis counter with wrap flag
//
// clk    : system clock
// reset  : synchronous, active-high; clears count
// en     : advance by one this clk
// count  : current position, 0 .. MAX-1
// wrap   : high in the enabled cycle where count moves from MAX-1 back to 0
module vga_counter #(
    parameter int MAX = 800,
    parameter int W   = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign wrap  = en && (count_q == LAST);
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = wrap ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vga_sync_controller.sv
// rtl/vga_sync_controller.sv - VGA raster timing generator and registered DAC output stage
//
// clk         : system clock
// reset       : synchronous, active-high
// pix_en      : pixel tick; counters and output stage advance only when high
// pixel_in    : colour for (pixel_x, pixel_y), valid in the same cycle
// pixel_x/y   : current horizontal / vertical count
// video_on    : current count lies in the visible area
// frame_start : one-clk pulse when a pixel tick lands on count (0,0)
// vga_r/g/b   : registered colour, forced to 0 during blanking
// vga_hsync   : registered horizontal sync
// vga_vsync   : registered vertical sync
// vga_blank_n : registered, low during blanking
// vga_sync_n  : constant 0, no sync-on-green
// vga_clk     : registered copy of pix_en, DAC strobe
module vga_sync_controller
    import vga_pkg::*;
#(
    parameter int DATA_WIDTH  = 24,
    parameter int COORD_W     = 10,
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int H_FP        = VGA_H_FP,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BP        = VGA_H_BP,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int V_FP        = VGA_V_FP,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BP        = VGA_V_BP,
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pix_en,
    input  logic [DATA_WIDTH-1:0]   pixel_in,
    output logic [COORD_W-1:0]      pixel_x,
    output logic [COORD_W-1:0]      pixel_y,
    output logic                    video_on,
    output logic                    frame_start,
    output logic [DATA_WIDTH/3-1:0] vga_r,
    output logic [DATA_WIDTH/3-1:0] vga_g,
    output logic [DATA_WIDTH/3-1:0] vga_b,
    output logic                    vga_hsync,
    output logic                    vga_vsync,
    output logic                    vga_blank_n,
    output logic                    vga_sync_n,
    output logic                    vga_clk
);

    localparam int CW      = DATA_WIDTH / 3;
    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [COORD_W-1:0] H_ACT_END = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT_END = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START  = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END    = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START  = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END    = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [COORD_W-1:0] h_count;
    logic [COORD_W-1:0] v_count;
    logic               h_wrap;
    logic               v_wrap;
    logic               v_en;
    logic               hsync_on;
    logic               vsync_on;

    logic [DATA_WIDTH-1:0] rgb_q,   rgb_d;
    logic                  blank_n_q, blank_n_d;
    logic                  hsync_q, hsync_d;
    logic                  vsync_q, vsync_d;
    logic                  vga_clk_q, vga_clk_d;
    logic                  origin_q, origin_d;

    vga_counter #(
        .MAX (H_TOTAL),
        .W   (COORD_W)
    ) u_h_counter (
        .clk   (clk),
        .reset (reset),
        .en    (pix_en),
        .count (h_count),
        .wrap  (h_wrap)
    );

    // h_wrap already includes pix_en; the explicit AND keeps the vertical
    // advance tied to a pixel tick even if the counter wrap is redefined.
    assign v_en = pix_en & h_wrap;

    vga_counter #(
        .MAX (V_TOTAL),
        .W   (COORD_W)
    ) u_v_counter (
        .clk   (clk),
        .reset (reset),
        .en    (v_en),
        .count (v_count),
        .wrap  (v_wrap)
    );

    assign pixel_x  = h_count;
    assign pixel_y  = v_count;
    assign video_on = (h_count < H_ACT_END) && (v_count < V_ACT_END);
    assign hsync_on = (h_count >= HS_START) && (h_count < HS_END);
    assign vsync_on = (v_count >= VS_START) && (v_count < VS_END);

    // origin_q tracks "counters sit at (0,0)" so frame_start needs no wide
    // compare: set by reset or a full-frame wrap, cleared by any other tick.
    always_comb begin
        origin_d = origin_q;
        if (pix_en) begin
            origin_d = v_wrap;
        end
    end

    assign frame_start = origin_q & pix_en & ~reset;

    always_comb begin
        rgb_d     = rgb_q;
        blank_n_d = blank_n_q;
        hsync_d   = hsync_q;
        vsync_d   = vsync_q;
        vga_clk_d = pix_en;
        if (pix_en) begin
            rgb_d     = video_on ? pixel_in : '0;
            blank_n_d = video_on;
            hsync_d   = hsync_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync_d   = vsync_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q     <= '0;
            blank_n_q <= 1'b0;
            hsync_q   <= ~SYNC_ACTIVE;
            vsync_q   <= ~SYNC_ACTIVE;
            vga_clk_q <= 1'b0;
            origin_q  <= 1'b1;
        end else begin
            rgb_q     <= rgb_d;
            blank_n_q <= blank_n_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            vga_clk_q <= vga_clk_d;
            origin_q  <= origin_d;
        end
    end

    assign vga_r       = rgb_q[DATA_WIDTH-1 -: CW];
    assign vga_g       = rgb_q[2*CW-1 -: CW];
    assign vga_b       = rgb_q[CW-1:0];
    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign vga_blank_n = blank_n_q;
    assign vga_sync_n  = 1'b0;
    assign vga_clk     = vga_clk_q;

endmodule

// File: tb/tb_vga_sync_controller.sv
// tb/tb_vga_sync_controller.sv - directed self-checking bench for vga_sync_controller
module tb_vga_sync_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_en;
    logic [23:0] pixel_in;

    always #5 clk = ~clk;

    // Full 640x480 timing instance.
    logic [9:0] x0, y0;
    logic       von0, fs0, hs0, vs0, bn0, sn0, vc0;
    logic [7:0] r0, g0, b0;

    // Reduced timing instance so a whole frame fits: 16 x 9 total,
    // 8x4 visible, hsync 10..12, vsync lines 5..6, frame = 144 ticks.
    logic [9:0] x1, y1;
    logic       von1, fs1, hs1, vs1, bn1, sn1, vc1;
    logic [7:0] r1, g1, b1;

    vga_sync_controller u_dut (
        .clk         (clk),
        .reset       (reset),
        .pix_en      (pix_en),
        .pixel_in    (pixel_in),
        .pixel_x     (x0),
        .pixel_y     (y0),
        .video_on    (von0),
        .frame_start (fs0),
        .vga_r       (r0),
        .vga_g       (g0),
        .vga_b       (b0),
        .vga_hsync   (hs0),
        .vga_vsync   (vs0),
        .vga_blank_n (bn0),
        .vga_sync_n  (sn0),
        .vga_clk     (vc0)
    );

    vga_sync_controller #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (2)
    ) u_small (
        .clk         (clk),
        .reset       (reset),
        .pix_en      (pix_en),
        .pixel_in    (pixel_in),
        .pixel_x     (x1),
        .pixel_y     (y1),
        .video_on    (von1),
        .frame_start (fs1),
        .vga_r       (r1),
        .vga_g       (g1),
        .vga_b       (b1),
        .vga_hsync   (hs1),
        .vga_vsync   (vs1),
        .vga_blank_n (bn1),
        .vga_sync_n  (sn1),
        .vga_clk     (vc1)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hs_low, hs_first, vs_low, vs_first, fs_cnt0, fs_cnt1, errs;
        logic [9:0]  sx;
        logic [23:0] srgb;
        logic        shs, sbn;

        reset    = 1'b1;
        pix_en   = 1'b1;
        pixel_in = 24'hFF0080;
        repeat (3) tick();

        chk("rst_x",       32'(x0), 0);
        chk("rst_y",       32'(y0), 0);
        chk("rst_hsync",   32'(hs0), 1);
        chk("rst_vsync",   32'(vs0), 1);
        chk("rst_blank_n", 32'(bn0), 0);
        chk("rst_rgb",     32'({r0, g0, b0}), 0);
        chk("rst_vga_clk", 32'(vc0), 0);
        chk("rst_sync_n",  32'(sn0), 0);
        chk("rst_fs",      32'(fs0), 0);

        reset = 1'b0;
        #1;
        chk("fs_first0", 32'(fs0), 1);
        chk("fs_first1", 32'(fs1), 1);

        hs_low = 0; hs_first = 0; vs_low = 0; vs_first = 0;
        fs_cnt0 = 0; fs_cnt1 = 0;
        for (int k = 1; k <= 800; k++) begin
            tick();
            if (hs0 == 1'b0) begin
                if (hs_low == 0) hs_first = k;
                hs_low++;
            end
            if (k <= 144 && vs1 == 1'b0) begin
                if (vs_low == 0) vs_first = k;
                vs_low++;
            end
            if (k <= 720 && fs1) fs_cnt1++;
            if (fs0) fs_cnt0++;
            if (k == 1) begin
                chk("rgb_first",   32'({r0, g0, b0}), 32'h00FF0080);
                chk("blank_first", 32'(bn0), 1);
            end
            if (k == 639) chk("von_639", 32'(von0), 1);
            if (k == 640) begin
                chk("von_640", 32'(von0), 0);
                chk("rgb_639", 32'({r0, g0, b0}), 32'h00FF0080);
            end
            if (k == 641) begin
                chk("rgb_640",   32'({r0, g0, b0}), 0);
                chk("blank_640", 32'(bn0), 0);
            end
            if (k == 656) chk("x_656", 32'(x0), 656);
            if (k == 799) begin
                chk("x_799", 32'(x0), 799);
                chk("y_799", 32'(y0), 0);
            end
            if (k == 800) begin
                chk("x_wrap", 32'(x0), 0);
                chk("y_inc",  32'(y0), 1);
            end
            if (k == 56) chk("small_rgb_active", 32'({r1, g1, b1}), 32'h00FF0080);
            if (k == 65) begin
                chk("small_rgb_vblank",   32'({r1, g1, b1}), 0);
                chk("small_blank_vblank", 32'(bn1), 0);
            end
        end
        chk("hsync_width", hs_low, 96);
        chk("hsync_first", hs_first, 657);
        chk("vsync_width", vs_low, 32);
        chk("vsync_first", vs_first, 81);
        chk("fs_per_frame_small", fs_cnt1, 5);
        chk("fs_none_midframe", fs_cnt0, 0);

        // Alternate pix_en: 800 pixels over 1600 clks, outputs frozen on idle clks.
        errs = 0;
        for (int i = 0; i < 800; i++) begin
            pix_en = 1'b0;
            sx   = x0;
            srgb = {r0, g0, b0};
            shs  = hs0;
            sbn  = bn0;
            tick();
            if (x0 !== sx || {r0, g0, b0} !== srgb || hs0 !== shs || bn0 !== sbn || vc0 !== 1'b0)
                errs++;
            pix_en = 1'b1;
            tick();
            if (x0 !== ((sx == 10'd799) ? 10'd0 : sx + 10'd1) || vc0 !== 1'b1)
                errs++;
        end
        chk("toggle_errs", errs, 0);
        chk("toggle_x", 32'(x0), 0);
        chk("toggle_y", 32'(y0), 2);

        repeat (300) tick();
        chk("pre_rst_x", 32'(x0), 300);
        chk("pre_rst_y", 32'(y0), 2);

        reset = 1'b1;
        tick();
        chk("mid_rst_x",       32'(x0), 0);
        chk("mid_rst_y",       32'(y0), 0);
        chk("mid_rst_blank_n", 32'(bn0), 0);
        chk("mid_rst_fs",      32'(fs0), 0);
        chk("mid_rst_small_x", 32'(x1), 0);
        chk("mid_rst_small_y", 32'(y1), 0);

        reset  = 1'b0;
        pix_en = 1'b0;
        #1;
        chk("post_rst_fs_idle", 32'(fs0), 0);
        tick();
        chk("post_rst_hold_x", 32'(x0), 0);
        chk("post_rst_fs_idle2", 32'(fs0), 0);
        pix_en = 1'b1;
        #1;
        chk("post_rst_fs", 32'(fs0), 1);
        tick();
        chk("post_rst_x1", 32'(x0), 1);
        chk("post_rst_fs_end", 32'(fs0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
